flot_isqrt_guard: RTL and testbench

FLOT_ISQRT_GUARD -- requirements
Module: flot_isqrt_guard

---
 rtl/flot_isqrt_guard.sv | 157 +++++++++++++++
 tb/tb_flot_isqrt_guard.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/flot_isqrt_guard.sv
// Guard logic around a pipelined inverse-square-root core: classifies special
// operands, substitutes their results, and adds valid/ready flow control.
module flot_isqrt_guard #(
  parameter int WIDTH     = 16,
  parameter int WIDTH_exp = 4,
  parameter int WIDTH_mat = 11,
  parameter int LAT       = 3
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] core_OP,
  output logic             core_CE,
  output logic             core_exce_in,
  input  logic [WIDTH-1:0] core_result,
  input  logic             core_exce_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_exce,
  output logic             busy
);

  localparam int CW = $clog2(LAT + 2);
  localparam logic [CW-1:0]        CNT_ONE   = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]        CNT_ZERO  = {CW{1'b0}};
  localparam logic [WIDTH_exp-1:0] EXP_ONES  = {WIDTH_exp{1'b1}};
  localparam logic [WIDTH_exp-1:0] EXP_ZERO  = {WIDTH_exp{1'b0}};
  localparam logic [WIDTH_mat-1:0] MAT_ZERO  = {WIDTH_mat{1'b0}};
  localparam logic [WIDTH-1:0]     WORD_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0]     QNAN_WORD = {1'b0, EXP_ONES, 1'b1, {(WIDTH_mat-1){1'b0}}};

  // Signed zero gets its own class so the tag alone rebuilds the result.
  typedef enum logic [2:0] {
    CLS_NORMAL = 3'd0,
    CLS_ZERO_P = 3'd1,
    CLS_ZERO_N = 3'd2,
    CLS_INF    = 3'd3,
    CLS_NEG    = 3'd4,
    CLS_NAN    = 3'd5
  } cls_e;

  typedef struct packed {
    logic vld;
    cls_e cls;
  } tag_t;

  function automatic cls_e classify(input logic [WIDTH-1:0] x);
    logic                 sgn;
    logic [WIDTH_exp-1:0] ex;
    logic [WIDTH_mat-1:0] mt;
    cls_e                 c;
    sgn = x[WIDTH-1];
    ex  = x[WIDTH-2 -: WIDTH_exp];
    mt  = x[WIDTH_mat-1:0];
    if (ex == EXP_ONES && mt != MAT_ZERO) c = CLS_NAN;
    else if (ex == EXP_ZERO)              c = sgn ? CLS_ZERO_N : CLS_ZERO_P;
    else if (sgn)                         c = CLS_NEG;
    else if (ex == EXP_ONES)              c = CLS_INF;
    else                                  c = CLS_NORMAL;
    return c;
  endfunction

  tag_t             tag_q [LAT];
  tag_t             tag_d [LAT];
  logic [WIDTH-1:0] op_q, op_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_exce_q, out_exce_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             stall_s, ce_s, accept_s, hs_s, load_s;
  cls_e             cls_s;
  tag_t             last_s;

  always_comb begin
    stall_s  = out_valid_q & ~out_ready;
    ce_s     = ~stall_s;
    accept_s = in_valid & ce_s;
    hs_s     = out_valid_q & out_ready;
    cls_s    = classify(in_data);
    last_s   = tag_q[LAT-1];
    load_s   = ce_s & last_s.vld;
  end

  // Tags shadow the core pipeline and move only while the core is enabled.
  always_comb begin
    op_d = op_q;
    for (int i = 0; i < LAT; i++) tag_d[i] = tag_q[i];
    if (ce_s) begin
      tag_d[0].vld = accept_s;
      tag_d[0].cls = cls_s;
      for (int i = 1; i < LAT; i++) tag_d[i] = tag_q[i-1];
      if (accept_s) op_d = (cls_s == CLS_NORMAL) ? in_data : WORD_ZERO;
      else          op_d = op_q;
    end else begin
      op_d = op_q;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_exce_d  = out_exce_q;
    if (load_s) begin
      out_valid_d = 1'b1;
      case (last_s.cls)
        CLS_NORMAL: begin out_data_d = core_result;                    out_exce_d = core_exce_out; end
        CLS_ZERO_P: begin out_data_d = {1'b0, EXP_ONES, MAT_ZERO};     out_exce_d = 1'b1;          end
        CLS_ZERO_N: begin out_data_d = {1'b1, EXP_ONES, MAT_ZERO};     out_exce_d = 1'b1;          end
        CLS_INF:    begin out_data_d = WORD_ZERO;                      out_exce_d = 1'b0;          end
        default:    begin out_data_d = QNAN_WORD;                      out_exce_d = 1'b1;          end
      endcase
    end else if (hs_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_comb begin
    case ({accept_s, hs_s})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
      op_q        <= WORD_ZERO;
      out_valid_q <= 1'b0;
      out_data_q  <= WORD_ZERO;
      out_exce_q  <= 1'b0;
      cnt_q       <= CNT_ZERO;
    end else begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= tag_d[i];
      op_q        <= op_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_exce_q  <= out_exce_d;
      cnt_q       <= cnt_d;
    end
  end

  assign in_ready     = ce_s;
  assign core_CE      = ce_s;
  assign core_exce_in = 1'b0;
  assign core_OP      = op_q;
  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_exce     = out_exce_q;
  assign busy         = (cnt_q != CNT_ZERO);

endmodule

// File: tb/tb_flot_isqrt_guard.sv
// Bench for flot_isqrt_guard: a behavioural core stand-in plus a class-based
// reference queue of expected {exce, data} results.
module tb_flot_isqrt_guard;
  localparam int LAT = 3;

  logic        CLK = 1'b0;
  logic        nRST, in_valid, in_ready, core_CE, core_exce_in, core_exce_out;
  logic        out_valid, out_ready, out_exce, busy;
  logic [15:0] in_data, core_OP, core_result, out_data;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [16:0] exp_q [$];

  always #5 CLK = ~CLK;

  flot_isqrt_guard #(.WIDTH(16), .WIDTH_exp(4), .WIDTH_mat(11), .LAT(LAT)) dut (
    .CLK(CLK), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .core_OP(core_OP), .core_CE(core_CE), .core_exce_in(core_exce_in),
    .core_result(core_result), .core_exce_out(core_exce_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_exce(out_exce), .busy(busy)
  );

  function automatic logic [15:0] core_fn(input logic [15:0] x);
    return {x[7:0], x[15:8]} ^ 16'hA5C3;
  endfunction

  // Stand-in core: OP register inside the guard plus LAT-1 enabled stages here.
  logic [15:0] core_pipe [LAT-1];
  always @(posedge CLK) begin
    if (core_CE) begin
      core_pipe[0] <= core_OP;
      for (int i = 1; i < LAT-1; i++) core_pipe[i] <= core_pipe[i-1];
    end
  end
  assign core_result   = core_fn(core_pipe[LAT-2]);
  assign core_exce_out = ^core_pipe[LAT-2];

  function automatic logic [16:0] ref_out(input logic [15:0] x);
    logic s; logic [3:0] e; logic [10:0] m;
    s = x[15]; e = x[14:11]; m = x[10:0];
    if (e == 4'hF && m != 11'd0) return {1'b1, 16'h7C00};
    if (e == 4'h0)               return {1'b1, s, 4'hF, 11'h000};
    if (s)                       return {1'b1, 16'h7C00};
    if (e == 4'hF)               return {1'b0, 16'h0000};
    return {^x, core_fn(x)};
  endfunction

  function automatic logic [15:0] rand_normal();
    return {1'b0, 4'($urandom_range(1, 14)), 11'($urandom)};
  endfunction

  function automatic logic [15:0] rand_op();
    logic s; logic [10:0] m;
    s = 1'($urandom_range(0, 1));
    m = 11'($urandom);
    case ($urandom_range(0, 7))
      0:       return {s, 4'h0, m};
      1:       return {s, 4'hF, 11'h000};
      2:       return {s, 4'hF, m | 11'h001};
      default: return {s, 4'($urandom_range(1, 14)), m};
    endcase
  endfunction

  task automatic drain();
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (LAT + 4) @(negedge CLK);
  endtask

  task automatic test_reset();
    nRST = 1'b0; in_valid = 1'b1; in_data = 16'h3C00; out_ready = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK); #1;
    n_cmp++; if (out_valid !== 1'b0)     begin n_fail++; $display("FAIL rst_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (out_data !== 16'h0000)  begin n_fail++; $display("FAIL rst_out_data got %h exp 0000", out_data); end
    n_cmp++; if (out_exce !== 1'b0)      begin n_fail++; $display("FAIL rst_out_exce got %b exp 0", out_exce); end
    n_cmp++; if (busy !== 1'b0)          begin n_fail++; $display("FAIL rst_busy got %b exp 0", busy); end
    n_cmp++; if (in_ready !== 1'b1)      begin n_fail++; $display("FAIL rst_in_ready got %b exp 1", in_ready); end
    n_cmp++; if (core_CE !== 1'b1)       begin n_fail++; $display("FAIL rst_core_CE got %b exp 1", core_CE); end
    n_cmp++; if (core_OP !== 16'h0000)   begin n_fail++; $display("FAIL rst_core_OP got %h exp 0000", core_OP); end
    n_cmp++; if (core_exce_in !== 1'b0)  begin n_fail++; $display("FAIL rst_core_exce_in got %b exp 0", core_exce_in); end
    in_valid = 1'b0; out_ready = 1'b1; nRST = 1'b1;
  endtask

  task automatic test_latency();
    logic e;
    @(negedge CLK); in_valid = 1'b1; in_data = 16'h3C00; out_ready = 1'b1; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL lat_in_ready got %b exp 1", in_ready); end
    @(negedge CLK); in_valid = 1'b0; #1;
    n_cmp++; if (core_OP !== 16'h3C00) begin n_fail++; $display("FAIL lat_core_OP got %h exp 3c00", core_OP); end
    n_cmp++; if (busy !== 1'b1) begin n_fail++; $display("FAIL lat_busy got %b exp 1", busy); end
    for (int k = 1; k <= LAT + 1; k++) begin
      if (k > 1) begin @(negedge CLK); #1; end
      e = (k == LAT + 1);
      n_cmp++; if (out_valid !== e) begin n_fail++; $display("FAIL lat_out_valid cycle %0d got %b exp %b", k, out_valid, e); end
    end
    n_cmp++; if (out_data !== core_fn(16'h3C00)) begin n_fail++; $display("FAIL lat_out_data got %h exp %h", out_data, core_fn(16'h3C00)); end
    n_cmp++; if (out_exce !== ^16'h3C00) begin n_fail++; $display("FAIL lat_out_exce got %b exp %b", out_exce, ^16'h3C00); end
    @(negedge CLK); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL lat_clear got %b exp 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL lat_idle_busy got %b exp 0", busy); end
  endtask

  task automatic test_specials();
    logic [15:0] sp_in  [8] = '{16'h0000, 16'hBC00, 16'h7800, 16'h7801, 16'h8000, 16'hF800, 16'hFC00, 16'h0005};
    logic [16:0] sp_exp [8] = '{17'h1_7800, 17'h1_7C00, 17'h0_0000, 17'h1_7C00, 17'h1_F800, 17'h1_7C00, 17'h1_7C00, 17'h1_7800};
    int sent = 0;
    int got  = 0;
    for (int t = 0; t < 40 && got < 8; t++) begin
      @(negedge CLK);
      in_valid = (sent < 8); in_data = (sent < 8) ? sp_in[sent] : 16'h0000; out_ready = 1'b1; #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL sp_in_ready t=%0d got %b exp 1", t, in_ready); end
      if (out_valid && out_ready) begin
        n_cmp++;
        if ({out_exce, out_data} !== sp_exp[got]) begin
          n_fail++; $display("FAIL sp_result #%0d got %h exp %h", got, {out_exce, out_data}, sp_exp[got]);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    n_cmp++; if (got !== 8) begin n_fail++; $display("FAIL sp_count got %0d exp 8", got); end
    drain();
  endtask

  task automatic test_stall();
    logic [15:0] ops [10];
    logic [15:0] held;
    logic [16:0] e;
    logic        rdy_exp;
    int sent = 0;
    int got  = 0;
    exp_q.delete();
    for (int i = 0; i < 10; i++) ops[i] = rand_normal();
    for (int t = 0; t < 60 && got < 10; t++) begin
      @(negedge CLK);
      in_valid = (sent < 10); in_data = (sent < 10) ? ops[sent] : 16'h0000;
      out_ready = !(t >= 6 && t <= 8); #1;
      rdy_exp = !(t >= 6 && t <= 8);
      n_cmp++; if (in_ready !== rdy_exp) begin n_fail++; $display("FAIL st_in_ready t=%0d got %b exp %b", t, in_ready, rdy_exp); end
      n_cmp++; if (core_CE !== rdy_exp) begin n_fail++; $display("FAIL st_core_CE t=%0d got %b exp %b", t, core_CE, rdy_exp); end
      if (t == 6) held = out_data;
      if (t == 7 || t == 8) begin
        n_cmp++; if (out_data !== held) begin n_fail++; $display("FAIL st_hold t=%0d got %h exp %h", t, out_data, held); end
      end
      if (out_valid && out_ready) begin
        e = (exp_q.size() != 0) ? exp_q.pop_front() : 17'h0_0000;
        n_cmp++; if ({out_exce, out_data} !== e) begin n_fail++; $display("FAIL st_result #%0d got %h exp %h", got, {out_exce, out_data}, e); end
        got++;
      end
      if (in_valid && in_ready) begin exp_q.push_back(ref_out(in_data)); sent++; end
    end
    n_cmp++; if (got !== 10) begin n_fail++; $display("FAIL st_count got %0d exp 10", got); end
    drain();
  endtask

  task automatic test_reset_midflight();
    logic [15:0] x;
    logic        e;
    for (int t = 0; t < 3; t++) begin
      @(negedge CLK); in_valid = 1'b1; in_data = rand_normal(); out_ready = 1'b1;
    end
    @(negedge CLK); in_valid = 1'b0; nRST = 1'b0;
    @(negedge CLK); #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mr_out_valid got %b exp 0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mr_busy got %b exp 0", busy); end
    nRST = 1'b1; x = rand_normal(); in_valid = 1'b1; in_data = x; #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mr_in_ready got %b exp 1", in_ready); end
    @(negedge CLK); in_valid = 1'b0;
    for (int k = 1; k <= LAT + 1; k++) begin
      if (k > 1) @(negedge CLK);
      #1;
      e = (k == LAT + 1);
      n_cmp++; if (out_valid !== e) begin n_fail++; $display("FAIL mr_out_valid cycle %0d got %b exp %b", k, out_valid, e); end
    end
    n_cmp++; if ({out_exce, out_data} !== ref_out(x)) begin n_fail++; $display("FAIL mr_result got %h exp %h", {out_exce, out_data}, ref_out(x)); end
    drain();
  endtask

  task automatic test_random();
    logic [15:0] cur;
    logic [16:0] e;
    logic        have = 1'b0;
    int sent = 0;
    int got  = 0;
    exp_q.delete();
    for (int t = 0; t < 20000 && (sent < 1000 || exp_q.size() != 0); t++) begin
      @(negedge CLK);
      if (!have) begin
        cur = rand_op();
        in_valid = (sent < 1000) && ($urandom_range(0, 9) < 7);
      end else begin
        in_valid = 1'b1;
      end
      in_data = cur;
      out_ready = ($urandom_range(0, 9) < 6); #1;
      n_cmp++; if (int'(dut.cnt_q) > LAT + 1) begin n_fail++; $display("FAIL rn_cnt_bound t=%0d got %0d exp <= %0d", t, dut.cnt_q, LAT + 1); end
      n_cmp++; if (int'(dut.cnt_q) != exp_q.size()) begin n_fail++; $display("FAIL rn_cnt t=%0d got %0d exp %0d", t, dut.cnt_q, exp_q.size()); end
      n_cmp++; if (busy !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rn_busy t=%0d got %b exp %b", t, busy, exp_q.size() != 0); end
      if (out_valid && out_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rn_extra t=%0d got %h exp none", t, {out_exce, out_data});
        end else begin
          e = exp_q.pop_front();
          if ({out_exce, out_data} !== e) begin n_fail++; $display("FAIL rn_result #%0d got %h exp %h", got, {out_exce, out_data}, e); end
        end
        got++;
      end
      if (in_valid && in_ready) begin exp_q.push_back(ref_out(in_data)); sent++; have = 1'b0; end
      else have = in_valid;
    end
    n_cmp++; if (sent != 1000 || got != 1000) begin n_fail++; $display("FAIL rn_count got %0d/%0d exp 1000/1000", sent, got); end
    drain();
  endtask

  initial begin
    nRST = 1'b0; in_valid = 1'b0; in_data = 16'h0000; out_ready = 1'b1;
    test_reset();
    test_latency();
    test_specials();
    test_stall();
    test_reset_midflight();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
